speech_sequencer: RTL

Plays spoken percentage announcements ("forty two percent used") from pre-recorded tracks in flash. On a start pulse it converts a 0–100 value into an ordered list of up to four track IDs. It then drives the flash manager's read port one sample per AC97 ready edge and forwards the high byte of each word to the headphone path. It sits between the top-level UI/battery logic and `flash_manager`. It owns the flash read port only while `busy` is high.

---
 rtl/speech_pkg.sv | 56 +++++
 rtl/speech_sequencer_if.sv | 20 ++
 rtl/speech_track_list.sv | 52 +++++
 rtl/speech_sequencer.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/speech_pkg.sv
// speech_pkg: track IDs, slot geometry and FSM encoding for speech_sequencer.
// Defining SPEECH_GAP_EN adds the inter-track silence state.
package speech_pkg;

  localparam int ID_W = 7;
  localparam int SLOT_SHIFT = 16;

  typedef logic [ID_W-1:0] track_id_t;
  typedef track_id_t [3:0] track_list_t;

  localparam track_id_t ONE      = 7'd1;
  localparam track_id_t TWO      = 7'd2;
  localparam track_id_t THREE    = 7'd3;
  localparam track_id_t FOUR     = 7'd4;
  localparam track_id_t FIVE     = 7'd5;
  localparam track_id_t SIX      = 7'd6;
  localparam track_id_t SEVEN    = 7'd7;
  localparam track_id_t EIGHT    = 7'd8;
  localparam track_id_t NINE     = 7'd9;
  localparam track_id_t TEN      = 7'd10;
  localparam track_id_t ELEVEN   = 7'd11;
  localparam track_id_t TWELVE   = 7'd12;
  localparam track_id_t THIRTEEN = 7'd13;
  localparam track_id_t FOURTEEN = 7'd14;
  localparam track_id_t FIFTEEN  = 7'd15;
  localparam track_id_t TEEN     = 7'd16;
  localparam track_id_t TWENTY   = 7'd18;
  localparam track_id_t THIRTY   = 7'd19;
  localparam track_id_t FORTY    = 7'd20;
  localparam track_id_t FIFTY    = 7'd21;
  localparam track_id_t SIXTY    = 7'd22;
  localparam track_id_t SEVENTY  = 7'd23;
  localparam track_id_t EIGHTY   = 7'd24;
  localparam track_id_t NINETY   = 7'd25;
  localparam track_id_t HUNDRED  = 7'd26;
  localparam track_id_t PERCENT  = 7'd27;
  localparam track_id_t USED     = 7'd28;
  localparam track_id_t HELP     = 7'd29;
  localparam track_id_t ZERO     = 7'd30;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_PLAY   = 3'd2,
    S_NEXT   = 3'd3,
`ifdef SPEECH_GAP_EN
    S_GAP    = 3'd5,
`endif
    S_FINISH = 3'd4
  } state_t;

  function automatic track_id_t ones_id(input logic [6:0] n);
    return (n == 7'd0) ? ZERO : track_id_t'(n);
  endfunction

endpackage

// File: rtl/speech_sequencer_if.sv
// speech_sequencer_if: flash manager read port owned by the sequencer.
// master = sequencer side, slave = flash manager side.
interface speech_sequencer_if #(
  parameter int ADDR_W = 23
);
  logic [ADDR_W-1:0] raddr;
  logic              doread;
  logic [15:0]       frdata;
  logic              flash_busy;

  modport master (
    output raddr, doread,
    input  frdata, flash_busy
  );

  modport slave (
    input  raddr, doread,
    output frdata, flash_busy
  );
endinterface

// File: rtl/speech_track_list.sv
// speech_track_list: maps a 0-127 percentage to up to four track IDs.
// Purely combinational; the sequencer registers the result on start.
module speech_track_list
  import speech_pkg::*;
(
  input  logic [6:0]  value,
  output track_list_t list,
  output logic [2:0]  count,
  output logic        range_flag
);

  logic [6:0] tens;
  logic [6:0] ones;

  always_comb begin
    tens = value / 7'd10;
    ones = value % 7'd10;
    list = '0;
    count = 3'd3;
    range_flag = 1'b0;
    list[1] = PERCENT;
    list[2] = USED;
    unique case (1'b1)
      value > 7'd100: begin
        list = '0;
        list[0] = HELP;
        count = 3'd1;
        range_flag = 1'b1;
      end
      value == 7'd100: list[0] = HUNDRED;
      value >= 7'd20 && value < 7'd100: begin
        list[0] = TWENTY + tens - 7'd2;
        if (ones != 7'd0) begin
          list[1] = ones_id(ones);
          list[2] = PERCENT;
          list[3] = USED;
          count = 3'd4;
        end
      end
      value >= 7'd16 && value < 7'd20: begin
        list[0] = ones_id(value - 7'd10);
        list[1] = TEEN;
        list[2] = PERCENT;
        list[3] = USED;
        count = 3'd4;
      end
      value >= 7'd10 && value < 7'd16: list[0] = TEN + (value - 7'd10);
      default: list[0] = ones_id(value);
    endcase
  end

endmodule

// File: rtl/speech_sequencer.sv
// speech_sequencer: plays a spoken percentage from flash, one sample per AC97 ready edge.
// Define SPEECH_GAP_EN to insert GAP_SAMPLES of silence between tracks.
module speech_sequencer
  import speech_pkg::*;
#(
  parameter int ADDR_W      = 23,
  parameter int TRACK_LEN   = 40000,
  parameter int GAP_SAMPLES = 2400
) (
  input  logic               clock,
  input  logic               reset_b,
  input  logic               start,
  input  logic               stop,
  input  logic [6:0]         value,
  input  logic               ready,
  speech_sequencer_if.master flash,
  output logic [7:0]         to_ac97_data,
  output logic               busy,
  output logic               done,
  output logic               range_err,
  output logic               underrun
);

  state_t            state, state_n;
  track_list_t       tl_list, list_r;
  logic [2:0]        tl_count, count_r;
  logic [2:0]        idx, idx_inc;
  logic              tl_range;
  logic [16:0]       cnt;
  logic [ADDR_W-1:0] raddr;
  logic              rdy_q1, rdy_q2;
  logic              rise, take, last;

  speech_track_list u_list (
    .value      (value),
    .list       (tl_list),
    .count      (tl_count),
    .range_flag (tl_range)
  );

  function automatic logic [ADDR_W-1:0] base_addr(input track_id_t id);
    return ADDR_W'(id) << SLOT_SHIFT;
  endfunction

  // rdy_q1 also serves as the synchronizer for the AC97-domain strobe
  assign rise    = rdy_q1 & ~rdy_q2;
  assign take    = rise & ~flash.flash_busy;
  assign last    = (cnt + 17'd1) == 17'(TRACK_LEN);
  assign idx_inc = idx + 3'd1;

  assign busy         = state != S_IDLE;
  assign done         = state == S_FINISH;
  assign flash.raddr  = raddr;
  assign flash.doread = busy & ~done;

`ifdef SPEECH_GAP_EN
  logic [15:0] gcnt;
  logic        glast;
  assign glast = (gcnt + 16'd1) == 16'(GAP_SAMPLES);
`endif

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) state <= S_IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:   if (start) state_n = S_LOAD;
      S_LOAD:   state_n = S_PLAY;
      S_PLAY: begin
        if (take && last) begin
`ifdef SPEECH_GAP_EN
          state_n = (idx_inc == count_r) ? S_NEXT : S_GAP;
`else
          state_n = S_NEXT;
`endif
        end
      end
`ifdef SPEECH_GAP_EN
      S_GAP:    if (rise && glast) state_n = S_NEXT;
`endif
      S_NEXT:   state_n = (idx_inc == count_r) ? S_FINISH : S_PLAY;
      S_FINISH: state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
    if (stop && busy && !done) state_n = S_FINISH;
  end

  // The list is captured on the accepting edge so raddr is already valid in LOAD
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      rdy_q1       <= 1'b0;
      rdy_q2       <= 1'b0;
      list_r       <= '0;
      count_r      <= '0;
      idx          <= '0;
      cnt          <= '0;
      raddr        <= '0;
      to_ac97_data <= '0;
      range_err    <= 1'b0;
      underrun     <= 1'b0;
`ifdef SPEECH_GAP_EN
      gcnt         <= '0;
`endif
    end else begin
      rdy_q1 <= ready;
      rdy_q2 <= rdy_q1;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            list_r    <= tl_list;
            count_r   <= tl_count;
            range_err <= tl_range;
            underrun  <= 1'b0;
            idx       <= '0;
            cnt       <= '0;
            raddr     <= base_addr(tl_list[0]);
          end
        end
        S_PLAY: begin
          if (rise) begin
            if (flash.flash_busy) begin
              underrun <= 1'b1;
            end else begin
              to_ac97_data <= flash.frdata[15:8];
              raddr        <= raddr + ADDR_W'(1);
              cnt          <= cnt + 17'd1;
            end
          end
        end
`ifdef SPEECH_GAP_EN
        S_GAP: begin
          if (rise) begin
            to_ac97_data <= '0;
            gcnt         <= gcnt + 16'd1;
          end
        end
`endif
        S_NEXT: begin
          idx <= idx_inc;
          cnt <= '0;
`ifdef SPEECH_GAP_EN
          gcnt <= '0;
`endif
          if (idx_inc != count_r)
            raddr <= base_addr(list_r[idx_inc[1:0]]);
        end
        default: ;
      endcase
      if (state_n == S_FINISH) to_ac97_data <= '0;
    end
  end

endmodule
